// File: rtl/symmetry_pattern_gen_if.sv
// -----------------------------------------------------------------------------
// symmetry_pattern_gen_if
//
// Purpose : valid/ready word channel between the symmetry pattern generator
//           (master) and the symmetry detector or any other consumer (slave).
//
// Signals :
//   word_out          [7:0]  generated word
//   word_valid               word_out / expected_mismatch are valid
//   word_ready               consumer accepts the word this cycle
//   expected_mismatch [2:0]  mismatched bit pairs the detector must report
// -----------------------------------------------------------------------------
interface symmetry_pattern_gen_if;
    logic [7:0] word_out;
    logic       word_valid;
    logic       word_ready;
    logic [2:0] expected_mismatch;

    modport master (
        output word_out,
        output word_valid,
        output expected_mismatch,
        input  word_ready
    );

    modport slave (
        input  word_out,
        input  word_valid,
        input  expected_mismatch,
        output word_ready
    );
endinterface

// File: rtl/symmetry_pattern_gen.sv
// -----------------------------------------------------------------------------
// symmetry_pattern_gen
//
// Purpose : self-test stimulus source for the symmetry detector. Emits a burst
//           of N_WORDS 8-bit words; each word is a 4-bit half-word mirrored
//           into the upper nibble, with a programmable number of bit pairs
//           deliberately broken. Every word carries the mismatch count the
//           detector is expected to report for it.
//
// Parameters:
//   N_WORDS  words per burst (1..256)
//   IDX_W    width of the word index counter (must hold N_WORDS-1)
//
// Ports:
//   clk              clock, all state on rising edge
//   rst_n            asynchronous active-low reset
//   start            begin a burst (sampled only in IDLE)
//   target_mismatch  requested broken pairs per word, saturates at 4
//   bus              master side of the word channel
//                    (word_out, word_valid, word_ready, expected_mismatch)
//   busy             high while the burst is running
//   done             one-cycle pulse after the last word is accepted
//
// Build option:
//   SYMGEN_LFSR_EN   when defined, the half-word comes from a 4-bit LFSR
//                    (x^4 + x^3 + 1) seeded to 4'b0001, instead of the index.
//
// State table:
//   IDLE | waiting for start, outputs zero
//   RUN  | presenting words, advancing on each handshake
//   FIN  | one-cycle done pulse, then back to IDLE
// -----------------------------------------------------------------------------
module symmetry_pattern_gen #(
    parameter int N_WORDS = 16,
    parameter int IDX_W   = 8
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          start,
    input  logic [2:0]                    target_mismatch,
    symmetry_pattern_gen_if.master        bus,
    output logic                          busy,
    output logic                          done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } state_t;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_WORDS - 1);

    state_t           state_q;
    logic [IDX_W-1:0] idx_q;
    logic [2:0]       tgt_q;
    logic             valid_q;
    logic             busy_q;
    logic             done_q;

    logic             hs;
    logic [3:0]       half;
    logic [1:0]       rot;
    logic [3:0]       mask_base;
    logic [3:0]       mask_rot;
    logic [7:0]       word_c;

    assign hs = valid_q & bus.word_ready;

    // -------------------------------------------------------------------------
    // Control FSM
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            tgt_q   <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        // Only 4 pairs exist in an 8-bit word.
                        tgt_q   <= (target_mismatch > 3'd4) ? 3'd4 : target_mismatch;
                        idx_q   <= '0;
                        valid_q <= 1'b1;
                        busy_q  <= 1'b1;
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    if (hs) begin
                        if (idx_q == LAST_IDX) begin
                            valid_q <= 1'b0;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            state_q <= FIN;
                        end else begin
                            idx_q <= idx_q + IDX_W'(1);
                        end
                    end
                end
                FIN: begin
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    valid_q <= 1'b0;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Half-word source
    // -------------------------------------------------------------------------
`ifdef SYMGEN_LFSR_EN
    logic [3:0] lfsr_q;

    // Fibonacci x^4 + x^3 + 1: shift toward MSB, feedback = bit3 ^ bit2 into
    // bit 0. Reseeded on every accepted start so each burst repeats exactly.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr_q <= 4'b0001;
        end else if (state_q == IDLE && start) begin
            lfsr_q <= 4'b0001;
        end else if (state_q == RUN && hs) begin
            lfsr_q <= {lfsr_q[2:0], lfsr_q[3] ^ lfsr_q[2]};
        end
    end

    assign half = lfsr_q;
`else
    // Index wraps modulo 16 for the half-word when bursts exceed 16 words.
    assign half = 4'(idx_q);
`endif

    assign rot = 2'(idx_q);

    // -------------------------------------------------------------------------
    // Word construction: combinational from registered state so the first
    // word is valid in the first RUN cycle and holds under backpressure.
    // -------------------------------------------------------------------------
    always_comb begin
        mask_base = 4'b0000;
        case (tgt_q)
            3'd0:    mask_base = 4'b0000;
            3'd1:    mask_base = 4'b0001;
            3'd2:    mask_base = 4'b0011;
            3'd3:    mask_base = 4'b0111;
            default: mask_base = 4'b1111;
        endcase
    end

    // Rotating the broken-pair mask with the index spreads the broken pairs
    // across all bit positions over a burst.
    always_comb begin
        mask_rot = mask_base;
        case (rot)
            2'd0: mask_rot = mask_base;
            2'd1: mask_rot = {mask_base[2:0], mask_base[3]};
            2'd2: mask_rot = {mask_base[1:0], mask_base[3:2]};
            2'd3: mask_rot = {mask_base[0],   mask_base[3:1]};
            default: mask_rot = mask_base;
        endcase
    end

    always_comb begin
        word_c      = 8'h00;
        word_c[3:0] = half;
        for (int k = 0; k < 4; k++) begin
            word_c[7-k] = half[k] ^ mask_rot[k];
        end
    end

    // -------------------------------------------------------------------------
    // Outputs (zero outside RUN)
    // -------------------------------------------------------------------------
    assign bus.word_valid        = valid_q;
    assign bus.word_out          = valid_q ? word_c : 8'h00;
    assign bus.expected_mismatch = valid_q ? tgt_q  : 3'd0;
    assign busy                  = busy_q;
    assign done                  = done_q;

endmodule

// File: tb/tb_symmetry_pattern_gen.sv
module tb_symmetry_pattern_gen;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start = 1'b0;
    logic [2:0] target = 3'd0;
    logic       busy;
    logic       done;

    symmetry_pattern_gen_if bus ();

    symmetry_pattern_gen #(
        .N_WORDS (16),
        .IDX_W   (8)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .start           (start),
        .target_mismatch (target),
        .bus             (bus),
        .busy            (busy),
        .done            (done)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] w;
        logic [2:0] m;
    } exp_t;

    exp_t sb_q[$];

    int checks   = 0;
    int errors   = 0;
    int hs_cnt   = 0;
    int busy_cnt = 0;
    int done_cnt = 0;

    bit         held = 1'b0;
    logic [7:0] held_w;
    logic [2:0] held_m;
    bit         prev_done = 1'b0;

`ifdef SYMGEN_LFSR_EN
    localparam int ABORT_HS = 10;
`else
    localparam int ABORT_HS = 7;
`endif

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
        end
    endtask

    function automatic logic [3:0] rev4(input logic [3:0] x);
        return {x[0], x[1], x[2], x[3]};
    endfunction

`ifdef SYMGEN_LFSR_EN
    // Hand-stepped x^4+x^3+1 sequence from seed 1.
    function automatic logic [3:0] lfsr_half(input int n);
        case (n)
            0: return 4'd1;   1: return 4'd2;   2: return 4'd4;
            3: return 4'd9;   4: return 4'd3;   5: return 4'd6;
            6: return 4'd13;  7: return 4'd10;  8: return 4'd5;
            9: return 4'd11; 10: return 4'd7;  11: return 4'd15;
            12: return 4'd14; 13: return 4'd12; default: return 4'd8;
        endcase
    endfunction
`endif

    // Expected word: perfect mirror, then the broken upper-nibble bits.
    // t=1 breaks pair k=i%4, i.e. upper bit 7-k; t=4 breaks every pair.
    function automatic logic [7:0] exp_word(input int t, input int i);
        logic [3:0] h;
        logic [7:0] flip;
`ifdef SYMGEN_LFSR_EN
        h = lfsr_half(i % 15);
`else
        h = 4'(i % 16);
`endif
        case (t)
            0:       flip = 8'h00;
            1:       flip = 8'(8'h80 >> (i % 4));
            default: flip = 8'hF0;
        endcase
        return {rev4(h), h} ^ flip;
    endfunction

    // ---------------------------------------------------------------------
    // Monitor / scoreboard
    // ---------------------------------------------------------------------
    always @(negedge clk) begin
        int   pc;
        exp_t e;
        if (done) begin
            done_cnt++;
            check("done_single_cycle", {31'd0, prev_done}, 32'd0);
        end
        prev_done = done;
        if (busy) busy_cnt++;

        if (held && rst_n) check("valid_held", {31'd0, bus.word_valid}, 32'd1);

        if (bus.word_valid) begin
            if (held) begin
                check("hold_word", {24'd0, bus.word_out}, {24'd0, held_w});
                check("hold_mism", {29'd0, bus.expected_mismatch}, {29'd0, held_m});
            end
            held   = !bus.word_ready;
            held_w = bus.word_out;
            held_m = bus.expected_mismatch;

            pc = 0;
            for (int k = 0; k < 4; k++) pc += int'(bus.word_out[7-k] ^ bus.word_out[k]);
            check("pair_count", pc, {29'd0, bus.expected_mismatch});

            if (bus.word_ready) begin
                hs_cnt++;
                if (sb_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL sb_underflow actual=0x%0h required=none", bus.word_out);
                end else begin
                    e = sb_q.pop_front();
                    check("word", {24'd0, bus.word_out}, {24'd0, e.w});
                    check("mism", {29'd0, bus.expected_mismatch}, {29'd0, e.m});
                end
            end
        end else begin
            held = 1'b0;
            check("idle_zero", {21'd0, bus.word_out, bus.expected_mismatch}, 32'd0);
        end
    end

    // ---------------------------------------------------------------------
    // Stimulus
    // ---------------------------------------------------------------------
    task automatic do_start(input logic [2:0] t);
        @(posedge clk); #1;
        start  = 1'b1;
        target = t;
        @(posedge clk); #1;
        start  = 1'b0;
        target = 3'd0;
    endtask

    task automatic run_burst(input logic [2:0] t, input int t_sat,
                             input int stall_at, input bit poke);
        int d0;
        int waited;
        for (int i = 0; i < 16; i++) sb_q.push_back({exp_word(t_sat, i), 3'(t_sat)});
        hs_cnt   = 0;
        busy_cnt = 0;
        d0       = done_cnt;
        bus.word_ready = 1'b1;
        do_start(t);
        check("first_valid", {31'd0, bus.word_valid}, 32'd1);
        check("first_word", {24'd0, bus.word_out}, {24'd0, exp_word(t_sat, 0)});

        if (poke) begin
            repeat (2) @(posedge clk);
            #1;
            start  = 1'b1;
            target = 3'd7;
            @(posedge clk); #1;
            start  = 1'b0;
            target = 3'd0;
        end

        if (stall_at >= 0) begin
            waited = 0;
            while (!(bus.word_valid && bus.word_out[3:0] == 4'(stall_at)) && waited < 50) begin
                @(posedge clk); #1;
                waited++;
            end
            check("stall_reached", {28'd0, bus.word_out[3:0]}, stall_at);
            bus.word_ready = 1'b0;
            repeat (3) @(posedge clk);
            #1;
            bus.word_ready = 1'b1;
        end

        waited = 0;
        while (done_cnt == d0 && waited < 100) begin
            @(posedge clk); #1;
            waited++;
        end
        check("burst_done", done_cnt - d0, 1);
        repeat (3) @(posedge clk);
        #1;
        check("done_once", done_cnt - d0, 1);
        check("word_count", hs_cnt, 16);
        check("busy_cycles", busy_cnt, (stall_at >= 0) ? 19 : 16);
        check("sb_empty", sb_q.size(), 0);
    endtask

    initial begin
        int d0;
        int waited;
        bus.word_ready = 1'b1;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #2;
        check("rst_word", {24'd0, bus.word_out}, 32'd0);
        check("rst_valid", {31'd0, bus.word_valid}, 32'd0);
        check("rst_mism", {29'd0, bus.expected_mismatch}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        run_burst(3'd0, 0, -1, 1'b0);
        run_burst(3'd1, 1, -1, 1'b0);
        run_burst(3'd7, 4, -1, 1'b0);
        run_burst(3'd0, 0, 5, 1'b0);

        // Abort mid-burst with reset.
        for (int i = 0; i < 16; i++) sb_q.push_back({exp_word(0, i), 3'd0});
        hs_cnt = 0;
        d0     = done_cnt;
        bus.word_ready = 1'b1;
        do_start(3'd0);
        waited = 0;
        while (bus.word_out != 8'hE7 && waited < 50) begin
            @(posedge clk); #1;
            waited++;
        end
        check("abort_reached", {24'd0, bus.word_out}, 32'hE7);
        rst_n = 1'b0;
        #1;
        check("abort_word", {24'd0, bus.word_out}, 32'd0);
        check("abort_valid", {31'd0, bus.word_valid}, 32'd0);
        check("abort_mism", {29'd0, bus.expected_mismatch}, 32'd0);
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_done", {31'd0, done}, 32'd0);
        sb_q.delete();
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("abort_no_done", done_cnt - d0, 0);
        check("abort_words", hs_cnt, ABORT_HS);
        check("post_abort_idle", {31'd0, busy}, 32'd0);

        // Fresh burst from index 0; a start pulse while busy is ignored.
        run_burst(3'd1, 1, -1, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

endmodule
